i2c_master_arbiter: RTL

- Shares one i2c_master instance between NUM_REQ independent requesters; the master is write-only, with a fixed byte count and a single-pulse request.
- Arbitrates round-robin, latches the winner's command, and issues a one-cycle request to the master.
- Tracks the transfer to completion through the master's ready line, then returns a per-requester done/error pulse.
- Sits between software- or FSM-driven clients (codec config, sensor poll) and the I2C master.

---
 rtl/i2c_arb_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 75 +++++++
 rtl/i2c_master_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/i2c_arb_pkg.sv
// Shared definitions for the I2C master arbiter: FSM encoding, error bit positions and
// requester-count limit.
package i2c_arb_pkg;

  localparam int unsigned MaxNumReq = 8;

  // Positions inside the {addr_err, noack_err} error vector.
  localparam int unsigned ErrAddr  = 1;
  localparam int unsigned ErrNoack = 0;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitBusy,
    StWaitDone,
    StComplete
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// One-hot requester pick for i2c_master_arbiter. Round-robin from a registered pointer by
// default; lowest-index fixed priority when I2C_ARB_FIXED_PRIO_EN is defined.
module rr_arbiter #(
  parameter int unsigned NumReq = 4,
  localparam int unsigned IdxW  = $clog2(NumReq)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NumReq-1:0] req_i,
  input  logic              advance_i,
  input  logic [IdxW-1:0]   last_idx_i,
  output logic [NumReq-1:0] grant_o,
  output logic [IdxW-1:0]   grant_idx_o
);

  logic        found;
  int unsigned idx;

`ifdef I2C_ARB_FIXED_PRIO_EN
  logic unused_ptr_inputs;
  assign unused_ptr_inputs = ^{clk_i, rst_ni, advance_i, last_idx_i};

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    idx         = 0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      idx = i;
      if (!found && req_i[idx[IdxW-1:0]]) begin
        found                    = 1'b1;
        grant_o[idx[IdxW-1:0]]   = 1'b1;
        grant_idx_o              = idx[IdxW-1:0];
      end
    end
  end
`else
  logic [IdxW-1:0] ptr_q, ptr_d;

  // The requester just served becomes lowest priority.
  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      ptr_d = (last_idx_i == IdxW'(NumReq - 1)) ? '0 : last_idx_i + IdxW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    idx         = 0;
    for (int unsigned off = 0; off < NumReq; off++) begin
      idx = 32'(ptr_q) + off;
      if (idx >= NumReq) begin
        idx = idx - NumReq;
      end
      if (!found && req_i[idx[IdxW-1:0]]) begin
        found                  = 1'b1;
        grant_o[idx[IdxW-1:0]] = 1'b1;
        grant_idx_o            = idx[IdxW-1:0];
      end
    end
  end
`endif

endmodule

// File: rtl/i2c_master_arbiter.sv
// Shares one write-only I2C master between NumReq requesters; grants, issues a single-cycle
// request, tracks the master's ready line and returns done/error. See I2C_ARB_FIXED_PRIO_EN.
module i2c_master_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int unsigned NumReq    = 4,
  parameter int unsigned ByteSize  = 8,
  parameter int unsigned NumByte   = 4,
  parameter int unsigned DataWidth = NumByte * ByteSize,
  localparam int unsigned AddrW    = ByteSize - 1,
  localparam int unsigned IdxW     = $clog2(NumReq)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NumReq-1:0]           req_valid_i,
  input  logic [NumReq-1:0]           req_wen_i,
  input  logic [NumReq*AddrW-1:0]     req_addr_i,
  input  logic [NumReq*DataWidth-1:0] req_wdata_i,
  output logic [NumReq-1:0]           req_grant_o,
  output logic [NumReq-1:0]           req_done_o,
  output logic [1:0]                  req_err_o,
  output logic                        busy_o,
  output logic                        m_req_o,
  output logic                        m_wen_o,
  output logic [AddrW-1:0]            m_slave_addr_o,
  output logic [DataWidth-1:0]        m_writedata_o,
  input  logic                        m_ready_i,
  input  logic                        m_addr_err_i,
  input  logic                        m_noack_err_i
);

  arb_state_e           state_q, state_d;
  logic                 wen_q, wen_d;
  logic [AddrW-1:0]     addr_q, addr_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [1:0]           flags_q, flags_d;
  logic                 m_req_q, m_req_d;
  logic                 m_ready_q;

  logic [NumReq-1:0]    pick_grant;
  logic [IdxW-1:0]      pick_idx;
  logic                 advance;
  logic                 grant_en;

  // Granting waits on the registered ready so that, after reset, the master must be
  // observed idle on a clock edge before any command is handed out.
  assign grant_en = (state_q == StIdle) && m_ready_q && (|req_valid_i);

  rr_arbiter #(
    .NumReq(NumReq)
  ) u_arb (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req_i      (req_valid_i),
    .advance_i  (advance),
    .last_idx_i (idx_q),
    .grant_o    (pick_grant),
    .grant_idx_o(pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    wen_d       = wen_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    idx_d       = idx_q;
    flags_d     = flags_q;
    m_req_d     = 1'b0;
    advance     = 1'b0;
    req_grant_o = '0;
    req_done_o  = '0;
    req_err_o   = '0;

    case (state_q)
      StIdle: begin
        if (grant_en) begin
          req_grant_o = pick_grant;
          idx_d       = pick_idx;
          flags_d     = '0;
          m_req_d     = 1'b1;
          state_d     = StIssue;
          for (int unsigned i = 0; i < NumReq; i++) begin
            if (pick_grant[i]) begin
              wen_d   = req_wen_i[i];
              addr_d  = req_addr_i[i*AddrW +: AddrW];
              wdata_d = req_wdata_i[i*DataWidth +: DataWidth];
            end
          end
        end
      end
      StIssue: begin
        if (m_ready_i) begin
          state_d = StWaitBusy;
        end else begin
          m_req_d = 1'b1;
        end
      end
      StWaitBusy: begin
        if (!m_ready_i) begin
          state_d = StWaitDone;
        end
      end
      StWaitDone: begin
        // Sticky; a pulse coincident with ready rising is still captured.
        flags_d[ErrAddr]  = flags_q[ErrAddr] | m_addr_err_i;
        flags_d[ErrNoack] = flags_q[ErrNoack] | m_noack_err_i;
        if (m_ready_i) begin
          state_d = StComplete;
        end
      end
      StComplete: begin
        for (int unsigned i = 0; i < NumReq; i++) begin
          req_done_o[i] = (idx_q == IdxW'(i));
        end
        req_err_o = flags_q;
        advance   = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      wen_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      idx_q     <= '0;
      flags_q   <= '0;
      m_req_q   <= 1'b0;
      m_ready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wen_q     <= wen_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      idx_q     <= idx_d;
      flags_q   <= flags_d;
      m_req_q   <= m_req_d;
      m_ready_q <= m_ready_i;
    end
  end

  assign busy_o         = (state_q != StIdle) | grant_en;
  assign m_req_o        = m_req_q;
  assign m_wen_o        = wen_q;
  assign m_slave_addr_o = addr_q;
  assign m_writedata_o  = wdata_q;

endmodule
